// File: rtl/decode_stage_if.sv
// Handshaked bus between fetch, the RV32I decode stage and execute.
// slave is the decode stage's view, master is the surrounding pipeline's.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic [XLEN-1:0] pc_in;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] pc_out;
    logic [3:0]      inst_type;
    logic [2:0]      imm_type;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] immediate;
    logic            illegal;

    modport slave (
        input  in_valid, instruction, pc_in, out_ready,
        output in_ready, out_valid, pc_out, inst_type, imm_type,
        output opcode, rd, rs1, rs2, func3, func7, immediate, illegal
    );

    modport master (
        output in_valid, instruction, pc_in, out_ready,
        input  in_ready, out_valid, pc_out, inst_type, imm_type,
        input  opcode, rd, rs1, rs2, func3, func7, immediate, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode into a registered output
// backed by a one-entry skid register for full throughput.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    decode_stage_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    typedef enum logic [2:0] {F_R, F_I, F_S, F_B, F_U, F_J} fmt_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [3:0]      inst_type;
        logic [2:0]      imm_type;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    localparam logic [2:0] IMM_NONE = 3'd7;

    state_t state_q;
    entry_t out_q;
    entry_t skid_q;
    entry_t dec_d;
    entry_t rst_e;

    logic [31:0] ins;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        accept;
    logic        fire;

    assign ins = bus.instruction;
    assign f3  = ins[14:12];
    assign f7  = ins[31:25];

    // Immediates built at 32 bits, then sign-extended to XLEN.
    logic signed [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
    assign imm_i32 = {{20{ins[31]}}, ins[31:20]};
    assign imm_s32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b32 = {{19{ins[31]}}, ins[31], ins[7],
                      ins[30:25], ins[11:8], 1'b0};
    assign imm_u32 = {ins[31:12], 12'b0};
    assign imm_j32 = {{11{ins[31]}}, ins[31], ins[19:12],
                      ins[20], ins[30:21], 1'b0};

    logic op_load, op_store, op_reg, op_imm, op_br;
    logic op_lui, op_auipc, op_jal, op_jalr, op_fence, op_sys;
    assign op_load  = ins[6:0] == 7'b0000011;
    assign op_store = ins[6:0] == 7'b0100011;
    assign op_reg   = ins[6:0] == 7'b0110011;
    assign op_imm   = ins[6:0] == 7'b0010011;
    assign op_br    = ins[6:0] == 7'b1100011;
    assign op_lui   = ins[6:0] == 7'b0110111;
    assign op_auipc = ins[6:0] == 7'b0010111;
    assign op_jal   = ins[6:0] == 7'b1101111;
    assign op_jalr  = ins[6:0] == 7'b1100111;
    assign op_fence = ins[6:0] == 7'b0001111;
    assign op_sys   = ins[6:0] == 7'b1110011;

    fmt_t       fmt;
    logic [3:0] ty;
    logic       ok;
    logic       shift;

    always_comb begin
        fmt   = F_I;
        ty    = 4'd0;
        ok    = 1'b0;
        shift = op_imm && (f3[1:0] == 2'b01);
        unique case (1'b1)
            op_load: begin
                ty = 4'd1; fmt = F_I;
                ok = !(f3 == 3'b011 || f3[2:1] == 2'b11);
            end
            op_store: begin
                ty = 4'd2; fmt = F_S; ok = f3 <= 3'b010;
            end
            op_reg: begin
                ty = 4'd3; fmt = F_R;
                ok = (f7 == 7'h00) ||
                     (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
            end
            op_imm: begin
                ty = 4'd4; fmt = F_I;
                if (f3 == 3'b001)      ok = f7 == 7'h00;
                else if (f3 == 3'b101) ok = f7 == 7'h00 || f7 == 7'h20;
                else                   ok = 1'b1;
            end
            op_br: begin
                ty = 4'd5; fmt = F_B; ok = f3[2:1] != 2'b01;
            end
            op_lui:   begin ty = 4'd6;  fmt = F_U; ok = 1'b1; end
            op_auipc: begin ty = 4'd7;  fmt = F_U; ok = 1'b1; end
            op_jal:   begin ty = 4'd8;  fmt = F_J; ok = 1'b1; end
            op_jalr: begin
                ty = 4'd9; fmt = F_I; ok = f3 == 3'b000;
            end
            op_fence: begin ty = 4'd10; fmt = F_I; ok = 1'b1; end
            op_sys:   begin ty = 4'd11; fmt = F_I; ok = 1'b1; end
            default:  ok = 1'b0;
        endcase
    end

    always_comb begin
        dec_d          = '0;
        dec_d.pc       = bus.pc_in;
        dec_d.opcode   = ins[6:0];
        dec_d.imm_type = IMM_NONE;
        if (ok) begin
            dec_d.inst_type = ty;
            unique case (fmt)
                F_R: begin
                    dec_d.rd    = ins[11:7];
                    dec_d.rs1   = ins[19:15];
                    dec_d.rs2   = ins[24:20];
                    dec_d.func3 = f3;
                    dec_d.func7 = f7;
                end
                F_I: begin
                    dec_d.rd       = ins[11:7];
                    dec_d.rs1      = ins[19:15];
                    dec_d.func3    = f3;
                    dec_d.func7    = shift ? f7 : 7'h00;
                    dec_d.imm_type = 3'd0;
                    dec_d.imm      = XLEN'(imm_i32);
                end
                F_S: begin
                    dec_d.rs1      = ins[19:15];
                    dec_d.rs2      = ins[24:20];
                    dec_d.func3    = f3;
                    dec_d.imm_type = 3'd1;
                    dec_d.imm      = XLEN'(imm_s32);
                end
                F_B: begin
                    dec_d.rs1      = ins[19:15];
                    dec_d.rs2      = ins[24:20];
                    dec_d.func3    = f3;
                    dec_d.imm_type = 3'd2;
                    dec_d.imm      = XLEN'(imm_b32);
                end
                F_U: begin
                    dec_d.rd       = ins[11:7];
                    dec_d.imm_type = 3'd3;
                    dec_d.imm      = XLEN'(imm_u32);
                end
                F_J: begin
                    dec_d.rd       = ins[11:7];
                    dec_d.imm_type = 3'd4;
                    dec_d.imm      = XLEN'(imm_j32);
                end
                default: dec_d.imm_type = IMM_NONE;
            endcase
        end else begin
            dec_d.illegal  = 1'b1;
            dec_d.imm_type = 3'd0;
        end
    end

    always_comb begin
        rst_e          = '0;
        rst_e.imm_type = IMM_NONE;
    end

    assign bus.in_ready = !rst && (state_q != TWO);
    assign accept       = bus.in_valid && bus.in_ready;
    assign fire         = (state_q != EMPTY) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            out_q   <= rst_e;
            skid_q  <= rst_e;
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) begin
                    out_q   <= dec_d;
                    state_q <= ONE;
                end
                ONE: begin
                    if (accept && fire) begin
                        out_q <= dec_d;
                    end else if (accept) begin
                        skid_q  <= dec_d;
                        state_q <= TWO;
                    end else if (fire) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: if (fire) begin
                    out_q   <= skid_q;
                    state_q <= ONE;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign bus.out_valid = state_q != EMPTY;
    assign bus.pc_out    = out_q.pc;
    assign bus.inst_type = out_q.inst_type;
    assign bus.imm_type  = out_q.imm_type;
    assign bus.opcode    = out_q.opcode;
    assign bus.rd        = out_q.rd;
    assign bus.rs1       = out_q.rs1;
    assign bus.rs2       = out_q.rs2;
    assign bus.func3     = out_q.func3;
    assign bus.func7     = out_q.func7;
    assign bus.immediate = out_q.imm;
    assign bus.illegal   = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Random and directed stimulus against a queue-based decode model.
// Expected entries come from an arithmetic decode of the encoding rules.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32)) bus ();

    decode_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]  ty;
        logic [2:0]  it;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;
    logic [6:0] ops [11];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] w,
                                     input logic [31:0] pc);
        exp_t e;
        int   sw, f3, f7, imm;
        byte  fmt;
        bit   legal;
        int   ty;
        sw    = $signed(w);
        f3    = int'(w[14:12]);
        f7    = int'(w[31:25]);
        e     = '0;
        e.pc  = pc;
        e.op  = w[6:0];
        e.it  = 3'd7;
        legal = 1'b1;
        fmt   = "I";
        ty    = 0;
        case (w[6:0])
            7'h03: begin ty = 1; legal = !(f3 inside {3, 6, 7}); end
            7'h23: begin ty = 2; fmt = "S"; legal = f3 <= 2; end
            7'h33: begin
                ty = 3; fmt = "R";
                legal = f7 == 0 || (f7 == 32 && f3 inside {0, 5});
            end
            7'h13: begin
                ty = 4;
                if (f3 == 1) legal = f7 == 0;
                if (f3 == 5) legal = f7 inside {0, 32};
            end
            7'h63: begin ty = 5; fmt = "B"; legal = !(f3 inside {2, 3}); end
            7'h37: begin ty = 6; fmt = "U"; end
            7'h17: begin ty = 7; fmt = "U"; end
            7'h6F: begin ty = 8; fmt = "J"; end
            7'h67: begin ty = 9; legal = f3 == 0; end
            7'h0F: ty = 10;
            7'h73: ty = 11;
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            e.ill = 1'b1;
            e.it  = 3'd0;
            return e;
        end
        e.ty = 4'(ty);
        imm  = 0;
        case (fmt)
            "R": begin
                e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
                e.f3 = w[14:12]; e.f7 = w[31:25];
            end
            "I": begin
                e.rd = w[11:7]; e.rs1 = w[19:15]; e.f3 = w[14:12];
                e.it = 3'd0;
                imm  = sw >>> 20;
                if (ty == 4 && f3 inside {1, 5}) e.f7 = w[31:25];
            end
            "S": begin
                e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f3 = w[14:12];
                e.it  = 3'd1;
                imm   = ((sw >>> 25) <<< 5) + int'(w[11:7]);
            end
            "B": begin
                e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f3 = w[14:12];
                e.it  = 3'd2;
                imm   = ((sw >>> 31) <<< 12) + (int'(w[7]) << 11)
                      + (int'(w[30:25]) << 5) + (int'(w[11:8]) << 1);
            end
            "U": begin
                e.rd = w[11:7]; e.it = 3'd3;
                imm  = sw & 32'hFFFFF000;
            end
            default: begin
                e.rd = w[11:7]; e.it = 3'd4;
                imm  = ((sw >>> 31) <<< 20) + (int'(w[19:12]) << 12)
                     + (int'(w[20]) << 11) + (int'(w[30:21]) << 1);
            end
        endcase
        e.imm = 32'(imm);
        return e;
    endfunction

    task automatic compare();
        check("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        check("in_ready", 64'(bus.in_ready), 64'(!rst && q.size() < 2));
        if (q.size() > 0) begin
            check("pc_out", 64'(bus.pc_out), 64'(q[0].pc));
            check("inst_type", 64'(bus.inst_type), 64'(q[0].ty));
            check("imm_type", 64'(bus.imm_type), 64'(q[0].it));
            check("opcode", 64'(bus.opcode), 64'(q[0].op));
            check("rd", 64'(bus.rd), 64'(q[0].rd));
            check("rs1", 64'(bus.rs1), 64'(q[0].rs1));
            check("rs2", 64'(bus.rs2), 64'(q[0].rs2));
            check("func3", 64'(bus.func3), 64'(q[0].f3));
            check("func7", 64'(bus.func7), 64'(q[0].f7));
            check("immediate", 64'(bus.immediate), 64'(q[0].imm));
            check("illegal", 64'(bus.illegal), 64'(q[0].ill));
        end
    endtask

    // Inputs change at the negedge; model and DUT update on the posedge.
    task automatic step(input logic r, input logic fl, input logic iv,
                        input logic ordy, input logic [31:0] ins,
                        input logic [31:0] pc);
        exp_t e;
        bit   acc;
        rst             = r;
        flush           = fl;
        bus.in_valid    = iv;
        bus.instruction = ins;
        bus.pc_in       = pc;
        bus.out_ready   = ordy;
        @(posedge clk);
        if (r || fl) begin
            q.delete();
        end else begin
            acc = iv && q.size() < 2;
            if (q.size() > 0 && ordy) e = q.pop_front();
            if (acc) q.push_back(ref_dec(ins, pc));
        end
        @(negedge clk);
        compare();
    endtask

    function automatic logic [31:0] rnd_ins();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 12);
        if (k < 11) w[6:0] = ops[k];
        if ($urandom_range(0, 1) == 1)
            w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return w;
    endfunction

    task automatic check_reset_vals();
        check("rst out_valid", 64'(bus.out_valid), 64'd0);
        check("rst in_ready", 64'(bus.in_ready), 64'd0);
        check("rst pc_out", 64'(bus.pc_out), 64'd0);
        check("rst imm_type", 64'(bus.imm_type), 64'd7);
        check("rst immediate", 64'(bus.immediate), 64'd0);
        check("rst inst_type", 64'(bus.inst_type), 64'd0);
        check("rst rd", 64'(bus.rd), 64'd0);
        check("rst illegal", 64'(bus.illegal), 64'd0);
    endtask

    localparam logic [31:0] LW   = 32'h00812283;
    localparam logic [31:0] SW   = 32'hFE60AE23;
    localparam logic [31:0] LUI  = 32'h123451B7;
    localparam logic [31:0] BAD  = 32'hFFFFFFFF;
    localparam logic [31:0] ADDI = 32'h00100093;

    initial begin
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h37,
                7'h17, 7'h6F, 7'h67, 7'h0F, 7'h73};
        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.instruction = '0; bus.pc_in = '0;
        @(negedge clk);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check_reset_vals();
        step(0, 0, 0, 1, 0, 0);
        check("ready after rst", 64'(bus.in_ready), 64'd1);

        step(0, 0, 1, 1, LW, 32'h100);
        check("lw type", 64'(bus.inst_type), 64'd1);
        check("lw imm_type", 64'(bus.imm_type), 64'd0);
        check("lw rd", 64'(bus.rd), 64'd5);
        check("lw rs1", 64'(bus.rs1), 64'd2);
        check("lw rs2", 64'(bus.rs2), 64'd0);
        check("lw func3", 64'(bus.func3), 64'd2);
        check("lw imm", 64'(bus.immediate), 64'h8);
        step(0, 0, 1, 1, SW, 32'h104);
        check("sw type", 64'(bus.inst_type), 64'd2);
        check("sw imm_type", 64'(bus.imm_type), 64'd1);
        check("sw rs1", 64'(bus.rs1), 64'd1);
        check("sw rs2", 64'(bus.rs2), 64'd6);
        check("sw rd", 64'(bus.rd), 64'd0);
        check("sw imm", 64'(bus.immediate), 64'hFFFFFFFC);
        step(0, 0, 1, 1, LUI, 32'h108);
        check("lui type", 64'(bus.inst_type), 64'd6);
        check("lui imm_type", 64'(bus.imm_type), 64'd3);
        check("lui rd", 64'(bus.rd), 64'd3);
        check("lui imm", 64'(bus.immediate), 64'h12345000);
        step(0, 0, 1, 1, BAD, 32'h10C);
        check("bad illegal", 64'(bus.illegal), 64'd1);
        check("bad type", 64'(bus.inst_type), 64'd0);
        step(0, 0, 0, 1, 0, 0);

        step(0, 0, 1, 0, ADDI, 32'h200);
        step(0, 0, 1, 0, ADDI, 32'h204);
        check("skid full ready", 64'(bus.in_ready), 64'd0);
        step(0, 0, 1, 0, ADDI, 32'h208);
        check("held A", 64'(bus.pc_out), 64'h200);
        step(0, 0, 1, 1, ADDI, 32'h208);
        check("order B", 64'(bus.pc_out), 64'h204);
        step(0, 0, 1, 1, ADDI, 32'h208);
        check("order C", 64'(bus.pc_out), 64'h208);
        step(0, 0, 0, 1, 0, 0);
        check("drained", 64'(bus.out_valid), 64'd0);

        step(0, 0, 1, 0, ADDI, 32'h300);
        step(0, 0, 1, 0, ADDI, 32'h304);
        step(0, 1, 1, 0, ADDI, 32'h308);
        check("flush valid", 64'(bus.out_valid), 64'd0);
        check("flush ready", 64'(bus.in_ready), 64'd1);
        step(0, 0, 0, 1, 0, 0);
        check("flush dropped", 64'(bus.out_valid), 64'd0);

        step(0, 0, 1, 0, ADDI, 32'h400);
        step(0, 0, 1, 0, ADDI, 32'h404);
        step(1, 0, 0, 0, 0, 0);
        check_reset_vals();
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, LW, 32'h500);
        check("lw after rst rd", 64'(bus.rd), 64'd5);
        check("lw after rst imm", 64'(bus.immediate), 64'h8);
        step(0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 6),
                 rnd_ins(), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
